// File: rtl/iic_scl_gen.sv
// SCL generator for the IIC controller: open-drain SCL drive, four phase strobes
// per period, slave clock-stretch detection with timeout, clean halt at period end.
module iic_scl_gen #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SCL_FREQ    = 100_000,
  parameter int STRETCH_MAX = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic scl_in,
  output logic scl_oe,
  output logic scl_hs,
  output logic scl_hc,
  output logic scl_ls,
  output logic scl_lc,
  output logic busy,
  output logic stretching,
  output logic stretch_to
);

  localparam int DIV = CLK_FREQ / SCL_FREQ;
  localparam int CW  = $clog2(DIV);
  localparam int SW  = $clog2(STRETCH_MAX + 1);

  localparam logic [CW-1:0] CNT_HS   = '0;
  localparam logic [CW-1:0] CNT_CHK  = CW'(DIV / 4 - 1);
  localparam logic [CW-1:0] CNT_HC   = CW'(DIV / 4);
  localparam logic [CW-1:0] CNT_LS   = CW'(DIV / 2);
  localparam logic [CW-1:0] CNT_LC   = CW'(3 * DIV / 4);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] STR_LAST = SW'(STRETCH_MAX - 1);

  generate
    if (DIV < 16 || (DIV % 4) != 0) begin : g_div_check
      $error("iic_scl_gen: CLK_FREQ/SCL_FREQ must be >= 16 and a multiple of 4");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stretch_q, stretch_d;
  logic          fault_q, fault_d;
  logic [1:0]    sync_q, sync_d;
  logic          scl_oe_q, scl_oe_d;
  logic          hs_q, hs_d;
  logic          hc_q, hc_d;
  logic          ls_q, ls_d;
  logic          lc_q, lc_d;
  logic          busy_q, busy_d;
  logic          stretching_q, stretching_d;
  logic          stretch_to_q, stretch_to_d;
  logic          scl_sync;
  logic          hold;
  logic          timeout;
  logic          run_d;

  assign scl_sync = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stretch_d = stretch_q;
    fault_d   = fault_q;
    sync_d    = {sync_q[0], scl_in};
    hold      = 1'b0;
    timeout   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        stretch_d = '0;
        if (!en) begin
          fault_d = 1'b0;
        end else if (!fault_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // The slave is only checked once per period, late enough for the synchroniser to see the release.
        if (cnt_q == CNT_CHK && !scl_sync) begin
          if (stretch_q == STR_LAST) begin
            timeout   = 1'b1;
            fault_d   = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
            stretch_d = '0;
          end else begin
            hold      = 1'b1;
            stretch_d = stretch_q + 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          stretch_d = '0;
          if (!en) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d     = cnt_q + 1'b1;
          stretch_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next count so strobes line up with the count value.
    run_d        = (state_d == RUN);
    scl_oe_d     = run_d && (cnt_d >= CNT_LS);
    hs_d         = run_d && (cnt_d == CNT_HS);
    hc_d         = run_d && (cnt_d == CNT_HC);
    ls_d         = run_d && (cnt_d == CNT_LS);
    lc_d         = run_d && (cnt_d == CNT_LC);
    busy_d       = run_d;
    stretching_d = hold;
    stretch_to_d = timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      stretch_q    <= '0;
      fault_q      <= 1'b0;
      sync_q       <= 2'b11;
      scl_oe_q     <= 1'b0;
      hs_q         <= 1'b0;
      hc_q         <= 1'b0;
      ls_q         <= 1'b0;
      lc_q         <= 1'b0;
      busy_q       <= 1'b0;
      stretching_q <= 1'b0;
      stretch_to_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stretch_q    <= stretch_d;
      fault_q      <= fault_d;
      sync_q       <= sync_d;
      scl_oe_q     <= scl_oe_d;
      hs_q         <= hs_d;
      hc_q         <= hc_d;
      ls_q         <= ls_d;
      lc_q         <= lc_d;
      busy_q       <= busy_d;
      stretching_q <= stretching_d;
      stretch_to_q <= stretch_to_d;
    end
  end

  assign scl_oe     = scl_oe_q;
  assign scl_hs     = hs_q;
  assign scl_hc     = hc_q;
  assign scl_ls     = ls_q;
  assign scl_lc     = lc_q;
  assign busy       = busy_q;
  assign stretching = stretching_q;
  assign stretch_to = stretch_to_q;

endmodule

// File: tb/tb_iic_scl_gen.sv
// Directed bench for iic_scl_gen with DIV=16 and STRETCH_MAX=32; the SCL pad
// reads back as the inverse of scl_oe unless a slave stretch is being forced.
module tb_iic_scl_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic force_low;
  logic scl_in;
  logic scl_oe, scl_hs, scl_hc, scl_ls, scl_lc, busy, stretching, stretch_to;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  iic_scl_gen #(
    .CLK_FREQ   (1_600_000),
    .SCL_FREQ   (100_000),
    .STRETCH_MAX(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .scl_in    (scl_in),
    .scl_oe    (scl_oe),
    .scl_hs    (scl_hs),
    .scl_hc    (scl_hc),
    .scl_ls    (scl_ls),
    .scl_lc    (scl_lc),
    .busy      (busy),
    .stretching(stretching),
    .stretch_to(stretch_to)
  );

  always #5 clk = ~clk;

  assign scl_in = force_low ? 1'b0 : !scl_oe;
  assign outs   = {scl_oe, scl_hs, scl_hc, scl_ls, scl_lc, busy, stretching, stretch_to};

  // Expected output vector while running, for a given count within the 16-clock period.
  function automatic logic [7:0] expRun(input int c);
    logic [7:0] v;
    v    = 8'h00;
    v[7] = (c >= 8);
    v[6] = (c == 0);
    v[5] = (c == 4);
    v[4] = (c == 8);
    v[3] = (c == 12);
    v[2] = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic e, input logic f);
    rst       = r;
    en        = e;
    force_low = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s @edge %0d: got %02h expected %02h", tag, edge_n, got, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset", outs, 8'h00);

    // Start: hs and busy on the first edge that samples en.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("start", outs, 8'h44);
    for (int i = 1; i <= 165; i++) begin
      tick();
      checkOutput("run", outs, expRun(i % 16));
    end

    // en drops at cnt 5: the period still completes, then idle with no strobes.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 6; c <= 15; c++) begin
      tick();
      checkOutput("drain", outs, expRun(c));
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle", outs, 8'h00);
    end

    // Stretch: SCL forced low from cnt 0, released 10 clocks later; 9 held clocks.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("str_hs", outs, 8'h44);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checkOutput("str_pre", outs, expRun(c));
    end
    for (int k = 4; k <= 12; k++) begin
      tick();
      checkOutput("str_hold", outs, 8'h06);
      if (k == 10) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    for (int c = 4; c <= 15; c++) begin
      tick();
      checkOutput("str_post", outs, expRun(c));
    end
    tick();
    checkOutput("str_wrap", outs, 8'h44);

    // Timeout: permanent stretch, 31 counted holds then the pulse on the 32nd.
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checkOutput("to_pre", outs, expRun(c));
    end
    for (int k = 4; k <= 34; k++) begin
      tick();
      checkOutput("to_hold", outs, 8'h06);
    end
    tick();
    checkOutput("to_pulse", outs, 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("to_fault", outs, 8'h00);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("to_clear", outs, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("to_restart", outs, 8'h44);

    // en briefly dropped mid-period and re-asserted before wrap: no gap.
    for (int c = 1; c <= 15; c++) begin
      tick();
      checkOutput("reen", outs, expRun(c));
      if (c == 5)  applyStimulus(1'b0, 1'b0, 1'b0);
      if (c == 10) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    tick();
    checkOutput("reen_wrap", outs, 8'h44);

    // Reset in the low phase clears everything; en still high restarts next edge.
    for (int c = 1; c <= 10; c++) begin
      tick();
      checkOutput("pre_rst", outs, expRun(c));
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("mid_rst", outs, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rst_restart", outs, 8'h44);
    tick();
    checkOutput("rst_run", outs, expRun(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
